// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: bus-mapped scan controller for the 8-digit seven-segment display.
// The CPU and a debug trace port share one pending frame buffer. The shown word
// changes only at the digit 7->0 wrap, so frame updates are tear-free.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module seg_scan_ctrl #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic             dbg_valid,
   input  logic [31:0]      dbg_data,
   output logic             dbg_ready,
   output logic [3:0]       nibble,
   output logic [7:0]       sel,
   output logic             frame_tick
);

   typedef enum logic [1:0] {
      A_DATA   = 2'd0,
      A_CTRL   = 2'd1,
      A_DIV    = 2'd2,
      A_STATUS = 2'd3
   } addr_t;

   addr_t              reg_sel;
   logic [31:0]        data_q;
   logic [31:0]        shown_q;
   logic [31:0]        pend_w_q;
   logic               pend_v_q;
   logic               en_q;
   logic               src_q;
   logic [7:0]         mask_q;
   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   cnt_q;
   logic [2:0]         idx_q;
   logic [7:0]         fcnt_q;

   logic [DIV_W-1:0]   div_eff;
   logic               div_wr;
   logic               tick;
   logic               wrap;
   logic               cpu_ld;
   logic               dbg_ld;
   logic [3:0]         cur_nib;
   logic [7:0]         lz;
   logic               blank;

   assign reg_sel   = addr_t'(addr);
   assign dbg_ready = src_q & ~pend_v_q;

   // Prescaler tick, frame wrap and load qualification for this cycle.
   // A DIV write restarts the slot, so it also suppresses the tick of that cycle.
   always_comb begin
      div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
      div_wr  = we && (reg_sel == A_DIV);
      tick    = !div_wr && (cnt_q == div_eff - DIV_W'(1));
      wrap    = tick && (idx_q == 3'd7);
      cpu_ld  = we && (reg_sel == A_DATA) && !src_q;
      dbg_ld  = dbg_valid && dbg_ready;
   end

   // Current digit nibble and its blanking decision.
   always_comb begin
      cur_nib = shown_q[{idx_q, 2'b00} +: 4];
      lz      = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every higher digit are zero;
      // digit 0 is excluded so a zero word still shows one digit.
      for (int unsigned i = 1; i < 8; i++) begin
         lz[i] = (shown_q >> (4 * i)) == 32'd0;
      end
`endif
      blank = !en_q || mask_q[idx_q] || lz[idx_q];
   end

   // Combinational register read-back.
   always_comb begin
      rdata = '0;
      case (reg_sel)
         A_DATA:   rdata = data_q;
         A_CTRL: begin
            rdata[0]    = en_q;
            rdata[1]    = src_q;
            rdata[15:8] = mask_q;
         end
         A_DIV:    rdata[DIV_W-1:0] = div_q;
         A_STATUS: begin
            rdata[2:0]  = idx_q;
            rdata[3]    = pend_v_q;
            rdata[15:8] = fcnt_q;
         end
         default:  rdata = '0;
      endcase
   end

   // Bus registers, prescaler, digit index, frame counter and frame buffering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q     <= '0;
         shown_q    <= '0;
         pend_w_q   <= '0;
         pend_v_q   <= 1'b0;
         en_q       <= 1'b1;
         src_q      <= 1'b0;
         mask_q     <= '0;
         div_q      <= DIV_W'(DEFAULT_DIV);
         cnt_q      <= '0;
         idx_q      <= '0;
         fcnt_q     <= '0;
         frame_tick <= 1'b0;
      end else begin
         if (we) begin
            case (reg_sel)
               A_DATA: data_q <= wdata;
               A_CTRL: begin
                  en_q   <= wdata[0];
                  src_q  <= wdata[1];
                  mask_q <= wdata[15:8];
               end
               A_DIV:  div_q <= wdata[DIV_W-1:0];
               default: ;
            endcase
         end

         if (div_wr || tick) cnt_q <= '0;
         else                cnt_q <= cnt_q + DIV_W'(1);

         if (tick) idx_q  <= idx_q + 3'd1;
         if (wrap) fcnt_q <= fcnt_q + 8'd1;
         frame_tick <= wrap;

         // The wrap consumes the old pending word; a load in the same cycle
         // refills pending for the following frame.
         if (wrap && pend_v_q) shown_q <= pend_w_q;
         if (cpu_ld) begin
            pend_w_q <= wdata;
            pend_v_q <= 1'b1;
         end else if (dbg_ld) begin
            pend_w_q <= dbg_data;
            pend_v_q <= 1'b1;
         end else if (wrap) begin
            pend_v_q <= 1'b0;
         end
      end
   end

   // Registered digit drive, one cycle behind the index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         nibble <= '0;
         sel    <= 8'h80;
      end else begin
         nibble <= cur_nib;
         sel    <= blank ? 8'h00 : (8'h80 >> idx_q);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with a behavioural display model.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        dbg_valid;
   logic [31:0] dbg_data;
   logic        dbg_ready;
   logic [3:0]  nibble;
   logic [7:0]  sel;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   seg_scan_ctrl #(.DIV_W(16), .DEFAULT_DIV(50000)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
      .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
      .nibble(nibble), .sel(sel), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       nib;
      logic [7:0]       sel;
      logic             ft;
      logic             rdy;
      logic [3:0][31:0] rd;
   } exp_t;

   exp_t sb[$];

   // Reference model state: what the display should be doing, in plain terms.
   logic [31:0] m_data, m_shown, m_pend_w;
   logic        m_pend_v, m_en, m_src;
   logic [7:0]  m_mask, m_fc;
   logic [15:0] m_div;
   int          m_cnt;
   logic [2:0]  m_idx;

   int   eff;
   bit   div_wr, tick, wrap, cpu_ld, dbg_ld, lzb;
   exp_t e;

   // Model update on each clock edge; expected outputs go to the scoreboard.
   always @(posedge clk) begin
      if (!reset) begin
         m_data = 0; m_shown = 0; m_pend_w = 0; m_pend_v = 0;
         m_en = 1; m_src = 0; m_mask = 0; m_div = 16'd50000;
         m_cnt = 0; m_idx = 0; m_fc = 0;
         e.nib = 4'h0; e.sel = 8'h80; e.ft = 1'b0;
      end else begin
         eff    = (m_div == 0) ? 1 : int'(m_div);
         div_wr = we && addr == 2'd2;
         tick   = !div_wr && (m_cnt == eff - 1);
         wrap   = tick && m_idx == 3'd7;
         cpu_ld = we && addr == 2'd0 && !m_src;
         dbg_ld = dbg_valid && m_src && !m_pend_v;
`ifdef SEG_LEADING_ZERO_BLANK_EN
         lzb = (m_idx != 0) && ((m_shown >> (4 * m_idx)) == 0);
`else
         lzb = 0;
`endif
         e.nib = 4'((m_shown >> (4 * m_idx)) & 32'hF);
         e.sel = (!m_en || m_mask[m_idx] || lzb) ? 8'h00 : (8'h80 >> m_idx);
         e.ft  = wrap;
         if (we && addr == 2'd0) m_data = wdata;
         if (we && addr == 2'd1) begin
            m_en = wdata[0]; m_src = wdata[1]; m_mask = wdata[15:8];
         end
         if (div_wr) m_div = wdata[15:0];
         m_cnt = (div_wr || tick) ? 0 : m_cnt + 1;
         if (tick) m_idx = m_idx + 3'd1;
         if (wrap) m_fc = m_fc + 8'd1;
         if (wrap && m_pend_v) begin
            m_shown  = m_pend_w;
            m_pend_v = 0;
         end
         if (cpu_ld) begin
            m_pend_w = wdata; m_pend_v = 1;
         end else if (dbg_ld) begin
            m_pend_w = dbg_data; m_pend_v = 1;
         end
      end
      e.rdy   = m_src && !m_pend_v;
      e.rd[0] = m_data;
      e.rd[1] = {16'h0, m_mask, 6'h0, m_src, m_en};
      e.rd[2] = {16'h0, m_div};
      e.rd[3] = {16'h0, m_fc, 4'h0, m_pend_v, m_idx};
      sb.push_back(e);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Monitor: pop one expectation per cycle and compare away from the clock edge.
   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("nibble", {28'h0, nibble}, {28'h0, x.nib});
         chk("sel", {24'h0, sel}, {24'h0, x.sel});
         chk("frame_tick", {31'h0, frame_tick}, {31'h0, x.ft});
         chk("dbg_ready", {31'h0, dbg_ready}, {31'h0, x.rdy});
         chk("rdata", rdata, x.rd[addr]);
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      cyc(1);
      we = 1'b0; addr = 2'd3;
   endtask

   // Hold a debug word until the handshake completes (bounded).
   task automatic dbg_send(logic [31:0] d);
      int n;
      n = 0;
      dbg_valid = 1'b1; dbg_data = d;
      while (n < 300) begin
         @(negedge clk);
         if (dbg_ready) break;
         n++;
      end
      n_checks++;
      if (n >= 300) begin
         n_fail++;
         $display("FAIL dbg_handshake timeout: actual=no_accept required=accept");
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue a DATA write landing exactly on the frame-wrap edge (bounded).
   task automatic wr_on_wrap(logic [31:0] d);
      int n;
      int ef;
      n = 0;
      while (n < 200) begin
         ef = (m_div == 0) ? 1 : int'(m_div);
         if (m_cnt == ef - 1 && m_idx == 3'd7) break;
         cyc(1);
         n++;
      end
      n_checks++;
      if (n >= 200) begin
         n_fail++;
         $display("FAIL wrap_wait timeout: actual=no_wrap required=wrap");
      end else begin
         wr(2'd0, d);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w;
      int r;
      reset = 1'b0; we = 1'b0; addr = 2'd3; wdata = '0;
      dbg_valid = 1'b0; dbg_data = '0;

      // Reset, then scan with DIV=4.
      cyc(2);
      reset = 1'b1;
      wr(2'd2, 32'd4);
      cyc(70);

      // CPU frame update mid-frame.
      wr(2'd0, 32'h1234_5678);
      cyc(70);

      // Debug handshake with a CPU store in between.
      wr(2'd2, 32'd2);
      wr(2'd1, 32'h0000_0003);
      dbg_send(32'hDEAD_BEEF);
      dbg_data = 32'hCAFE_F00D;
      wr(2'd0, 32'h1111_2222);
      addr = 2'd0;
      cyc(3);
      addr = 2'd3;
      dbg_send(32'hCAFE_F00D);
      dbg_valid = 1'b0;
      cyc(40);

      // Mask low digits with DIV=0, then disable.
      wr(2'd1, 32'h0000_0F01);
      wr(2'd2, 32'd0);
      cyc(24);
      wr(2'd1, 32'h0000_0F00);
      cyc(24);

      // Store on the exact wrap edge, and DIV rewrite mid-count.
      wr(2'd1, 32'h0000_0001);
      wr(2'd2, 32'd2);
      cyc(5);
      wr_on_wrap(32'h9ABC_DEF0);
      cyc(40);
      wr(2'd2, 32'd5);
      cyc(2);
      wr(2'd2, 32'd3);
      cyc(30);

      // Randomized mix of stores, control changes, debug offers and resets.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         we = 1'b0; addr = 2'($urandom_range(0, 3));
         wdata = $urandom;
         dbg_valid = ($urandom_range(0, 1) == 1);
         dbg_data = $urandom;
         reset = ($urandom_range(0, 299) != 0);
         if (r < 10) begin
            we = 1'b1; addr = 2'd0;
         end else if (r < 13) begin
            we = 1'b1; addr = 2'd1;
            w = $urandom;
            w[0] = ($urandom_range(0, 3) != 0);
            wdata = w;
         end else if (r < 15) begin
            we = 1'b1; addr = 2'd2; wdata = $urandom_range(0, 3);
         end else if (r < 16) begin
            we = 1'b1; addr = 2'd3;
         end
         cyc(1);
      end
      we = 1'b0; dbg_valid = 1'b0; reset = 1'b1; addr = 2'd3;

      // Zero shown word after reset: only digit 0 may be auto-kept.
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      wr(2'd2, 32'd1);
      cyc(20);

      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Bus-mapped controller that sequences the 8-digit seven-segment scan datapath of the MIPS microsystem. It shares the display between two requesters: CPU stores through the device bridge, and a debug trace port using a valid/ready handshake. It owns the refresh prescaler, the digit index, the per-digit blanking and tear-free frame updates. It emits one nibble plus a one-hot digit select per scan slot to the segment decoder.

Parameters:
DIV_W, 16, width of prescaler and DIV register
DEFAULT_DIV, 50000, reset value of DIV (clk cycles per digit slot)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk
we  in  1  bus write strobe, one cycle per store
addr  in  2  word address: 0 DATA, 1 CTRL, 2 DIV, 3 STATUS
wdata  in  32  bus write data
rdata  out  32  combinational read data for addr
dbg_valid  in  1  debug word offered
dbg_data  in  32  debug word
dbg_ready  out  1  debug word can be accepted this cycle
nibble  out  4  hex nibble for current digit, registered
sel  out  8  one-hot digit enable, registered; all-zero when blanked
frame_tick  out  1  one-cycle pulse when digit index wraps 7->0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low; all state changes on posedge clk only.
- Reset values:
  - DATA=0, shown word=0, pending empty.
  - CTRL: en=1, src=0, mask=0.
  - DIV=DEFAULT_DIV, prescaler=0, idx=0, frame count=0.
  - Outputs: nibble=0, sel=8'h80, frame_tick=0, dbg_ready=0.
  - A reset asserted mid-frame takes priority over every other event in that cycle.
- Register map:
  - CTRL bits: [0] en, [1] src (0 = CPU, 1 = debug), [15:8] mask (bit i blanks digit i).
  - STATUS (read-only): [2:0] idx, [3] pending, [15:8] frame count (8-bit, wraps 255->0).
  - Writes to STATUS are ignored.
  - rdata for DATA, CTRL and DIV returns the last written value; unused bits read 0.
- Prescaler:
  - Counts 0..DIV-1 and emits an internal tick when count == DIV-1, then wraps to 0.
  - DIV=0 behaves as DIV=1 (tick every cycle).
  - A write to DIV also clears the prescaler count in the same cycle.
  - Ticks continue while en=0.
- Digit index: increments on tick. On the 7->0 wrap: frame_tick pulses for that cycle, frame count increments, and the pending word (if any) moves into the shown word and pending clears.
- CPU path:
  - A DATA write always updates the DATA register.
  - If src=0, the same write also loads pending. A later write before the frame boundary overwrites pending; last write wins.
- Debug path:
  - dbg_ready = src & ~pending.
  - Accept when dbg_valid & dbg_ready: dbg_data goes into pending.
  - At most one debug word is accepted per frame.
  - When src=0, dbg_ready=0 and debug words are never taken.
- Source arbitration:
  - A CPU write and a debug offer in the same cycle: only the source selected by src is accepted.
  - A CTRL write changing src takes effect the next cycle. Pending is kept.
- Output stage (registered, 1-cycle latency after the idx update):
  - nibble = shown[4*idx+3 : 4*idx].
  - sel = 8'h80 >> idx.
  - sel = 0 when en=0 or mask[idx]=1; nibble still updates while blanked.
- Boundary case: a pending load and a frame wrap in the same cycle. The wrap transfers the old pending; the new word becomes pending for the next frame.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Digits 7 down to 1 are additionally blanked while they and all higher digits of the shown word are zero.
  - Digit 0 is never auto-blanked.
  - Example: shown = 0x0000_00A5 displays only digits 1 and 0.
- Undefined: blanking comes only from en and mask; all zero digits are displayed.

Test Plan:
- Reset behaviour: reset=0 for 2 cycles with DIV=4 -> sel=8'h80, nibble=0, STATUS=0. Then reset=1 -> sel steps 80,40,20,...,01 every 4 cycles, and frame_tick pulses once per 32 cycles.
- CPU write: write DATA=0x12345678 mid-frame with src=0 -> slots keep showing 0 until the wrap. Next frame shows nibbles 8,7,6,5,4,3,2,1 with sel 80..01; STATUS[3] goes 1 then 0.
- Debug handshake: src=1, dbg_valid held with 0xDEADBEEF then 0xCAFEF00D.
  - First word accepted; dbg_ready=0 until the wrap; second word accepted right after the wrap.
  - Displays DEADBEEF for one frame, then CAFEF00D.
  - A CPU DATA write in the same period is readable but not displayed.
- Blanking and DIV=0: mask=8'h0F, DIV=0 -> sel=0 in slots 0-3 and one-hot in slots 4-7, advancing every cycle. Then en=0 -> sel=0 in all slots, and frame_tick keeps pulsing every 8 cycles.
- Boundary and optional feature:
  - A DATA write in the exact wrap cycle appears only one frame later.
  - A DIV write of 3 mid-count restarts slot timing at 3 cycles.
  - With SEG_LEADING_ZERO_BLANK_EN, shown=0x00000000 -> only sel=8'h80 (digit 0) is ever driven.
